// File: rtl/rect_flip_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rect_flip_ctrl
// Purpose  : Walks a rectangular BRAM region through a wowi_adapter, flipping
//            each word (byte-swap or bit-reverse) and writing it back in place.
// Revision : 1.0  initial release
// ============================================================================
module rect_flip_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_BYTES = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DIM_WIDTH  = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            origin_addr,
    input  logic [ADDR_WIDTH-1:0]            stride,
    input  logic [DIM_WIDTH-1:0]             rows,
    input  logic [DIM_WIDTH-1:0]             cols,
    input  logic                             mode,
    output logic                             st_read,
    output logic                             st_write,
    output logic [ADDR_WIDTH-1:0]            base_addr,
    output logic [WORD_BYTES*DATA_WIDTH-1:0] write_data,
    input  logic [WORD_BYTES*DATA_WIDTH-1:0] read_data,
    input  logic                             flip_ready,
    input  logic                             wrt_done,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic [2*DIM_WIDTH-1:0]           word_count
);

    localparam int c_word_w = WORD_BYTES * DATA_WIDTH;
    localparam int c_tmr_w  = $clog2(TIMEOUT + 1);

    localparam logic [c_tmr_w-1:0]     c_tmr_one  = c_tmr_w'(1);
    localparam logic [c_tmr_w-1:0]     c_tmr_last = c_tmr_w'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0]  c_addr_step = ADDR_WIDTH'(WORD_BYTES);
    localparam logic [DIM_WIDTH:0]     c_dim_one  = (DIM_WIDTH+1)'(1);
    localparam logic [DIM_WIDTH-1:0]   c_idx_one  = DIM_WIDTH'(1);
    localparam logic [2*DIM_WIDTH-1:0] c_wc_one   = (2*DIM_WIDTH)'(1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_read    = 3'd1;
    localparam logic [2:0] c_st_flip    = 3'd2;
    localparam logic [2:0] c_st_write   = 3'd3;
    localparam logic [2:0] c_st_wr_wait = 3'd4;
    localparam logic [2:0] c_st_settle  = 3'd5;
    localparam logic [2:0] c_st_done    = 3'd6;

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [c_tmr_w-1:0]     r_timer;
    logic [ADDR_WIDTH-1:0]  r_stride;
    logic [ADDR_WIDTH-1:0]  r_row_base;
    logic [ADDR_WIDTH-1:0]  r_base_addr;
    logic [DIM_WIDTH-1:0]   r_rows;
    logic [DIM_WIDTH-1:0]   r_cols;
    logic [DIM_WIDTH-1:0]   r_row;
    logic [DIM_WIDTH-1:0]   r_col;
    logic                   r_mode;
    logic                   r_err;
    logic [2*DIM_WIDTH-1:0] r_word_count;
    logic [c_word_w-1:0]    r_read_data;
    logic [c_word_w-1:0]    r_write_data;
    logic [c_word_w-1:0]    w_byteswap;
    logic [c_word_w-1:0]    w_bitrev;
    logic                   w_timeout;
    logic                   w_col_more;
    logic                   w_row_more;

    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_byteswap
        assign w_byteswap[gi*DATA_WIDTH +: DATA_WIDTH] =
            r_read_data[(WORD_BYTES-1-gi)*DATA_WIDTH +: DATA_WIDTH];
    end

    for (genvar gk = 0; gk < c_word_w; gk++) begin : g_bitrev
        assign w_bitrev[gk] = r_read_data[c_word_w-1-gk];
    end

    assign w_timeout  = (r_timer == c_tmr_last);
    assign w_col_more = (({1'b0, r_col} + c_dim_one) < {1'b0, r_cols});
    assign w_row_more = (({1'b0, r_row} + c_dim_one) < {1'b0, r_rows});

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (start)
                    w_state_nxt = (rows == '0 || cols == '0) ? c_st_done : c_st_read;
            end
            c_st_read: begin
                if (flip_ready)     w_state_nxt = c_st_flip;
                else if (w_timeout) w_state_nxt = c_st_done;
            end
            c_st_flip:  w_state_nxt = c_st_write;
            c_st_write: w_state_nxt = c_st_wr_wait;
            c_st_wr_wait: begin
                if (wrt_done)       w_state_nxt = c_st_settle;
                else if (w_timeout) w_state_nxt = c_st_done;
            end
            c_st_settle: w_state_nxt = (w_col_more || w_row_more) ? c_st_read : c_st_done;
            c_st_done:   w_state_nxt = c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_timer      <= '0;
            r_stride     <= '0;
            r_row_base   <= '0;
            r_base_addr  <= '0;
            r_rows       <= '0;
            r_cols       <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_mode       <= 1'b0;
            r_err        <= 1'b0;
            r_word_count <= '0;
            r_read_data  <= '0;
            r_write_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= (w_state_nxt != r_state) ? '0 : r_timer + c_tmr_one;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_stride     <= stride;
                        r_rows       <= rows;
                        r_cols       <= cols;
                        r_mode       <= mode;
                        r_row        <= '0;
                        r_col        <= '0;
                        r_row_base   <= origin_addr;
                        r_base_addr  <= origin_addr;
                        r_word_count <= '0;
                        r_err        <= 1'b0;
                    end
                end
                c_st_read: begin
                    if (flip_ready)     r_read_data <= read_data;
                    else if (w_timeout) r_err       <= 1'b1;
                end
                c_st_flip: r_write_data <= r_mode ? w_bitrev : w_byteswap;
                c_st_wr_wait: begin
                    if (wrt_done)       r_word_count <= r_word_count + c_wc_one;
                    else if (w_timeout) r_err        <= 1'b1;
                end
                // Row base is tracked incrementally so no multiplier is needed.
                c_st_settle: begin
                    if (w_col_more) begin
                        r_col       <= r_col + c_idx_one;
                        r_base_addr <= r_base_addr + c_addr_step;
                    end else if (w_row_more) begin
                        r_col       <= '0;
                        r_row       <= r_row + c_idx_one;
                        r_row_base  <= r_row_base + r_stride;
                        r_base_addr <= r_row_base + r_stride;
                    end
                end
                default: ;
            endcase
        end
    end

    assign st_read    = (r_state == c_st_read);
    assign st_write   = (r_state == c_st_write);
    assign busy       = (r_state == c_st_read)  || (r_state == c_st_flip)    ||
                        (r_state == c_st_write) || (r_state == c_st_wr_wait) ||
                        (r_state == c_st_settle);
    assign done       = (r_state == c_st_done);
    assign err        = r_err;
    assign base_addr  = r_base_addr;
    assign write_data = r_write_data;
    assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_rect_flip_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rect_flip_ctrl
// Purpose  : Directed self-checking bench for rect_flip_ctrl with a small
//            behavioural adapter/BRAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rect_flip_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  origin_addr;
    logic [7:0]  stride;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        mode;
    logic        st_read;
    logic        st_write;
    logic [7:0]  base_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        flip_ready = 1'b0;
    logic        wrt_done   = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  word_count;

    int n_cmp = 0;
    int n_err = 0;

    rect_flip_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .origin_addr (origin_addr),
        .stride      (stride),
        .rows        (rows),
        .cols        (cols),
        .mode        (mode),
        .st_read     (st_read),
        .st_write    (st_write),
        .base_addr   (base_addr),
        .write_data  (write_data),
        .read_data   (read_data),
        .flip_ready  (flip_ready),
        .wrt_done    (wrt_done),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .word_count  (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adapter model: read latency rd_lat, write latency wr_lat, flags cleared
    // once the request drops (read) or after one cycle (write).
    logic [15:0] mem [0:255];
    logic        rd_en;
    int          rd_lat;
    int          wr_lat;
    int          rd_cnt  = 0;
    int          wr_cnt  = 0;
    logic        wr_pend = 1'b0;
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;
    logic [7:0]  wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    logic        hs_viol = 1'b0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (!st_read) begin
            flip_ready <= 1'b0;
            rd_cnt     <= 0;
        end else if (rd_en && !flip_ready) begin
            if (rd_cnt + 1 >= rd_lat) begin
                flip_ready <= 1'b1;
                read_data  <= mem[base_addr];
            end else begin
                rd_cnt <= rd_cnt + 1;
            end
        end
        wrt_done <= 1'b0;
        if (st_write) begin
            mem[base_addr] <= write_data;
            wr_addr_q.push_back(base_addr);
            wr_data_q.push_back(write_data);
            wr_pend <= 1'b1;
            wr_cnt  <= 0;
        end else if (wr_pend) begin
            if (wr_cnt + 1 >= wr_lat) begin
                wrt_done <= 1'b1;
                wr_pend  <= 1'b0;
            end else begin
                wr_cnt <= wr_cnt + 1;
            end
        end
        if ((st_read && st_write) || (st_read && wrt_done) || (st_write && flip_ready))
            hs_viol <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Starts a pass and waits for done; inject fires a second start mid-pass.
    task automatic run_pass(input logic [7:0] org, input logic [7:0] strd,
                            input logic [3:0] nr, input logic [3:0] nc,
                            input logic m, input bit inject,
                            output logic [7:0] wc, output logic e,
                            output logic busy_drop);
        int cyc;
        origin_addr = org;
        stride      = strd;
        rows        = nr;
        cols        = nc;
        mode        = m;
        start       = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cyc       = 0;
        busy_drop = 1'b0;
        while (!done && cyc < 400) begin
            if (!busy) busy_drop = 1'b1;
            @(negedge clk);
            cyc++;
            if (inject && cyc == 3) begin
                origin_addr = 8'h40;
                rows        = 4'd1;
                cols        = 4'd1;
                mode        = 1'b1;
                start       = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        if (!done) check("done_seen", 32'd0, 32'd1);
        wc = word_count;
        e  = err;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  wc;
        logic        e;
        logic        bd;
        int          b;
        int          cnt;
        logic        seen;
        logic        traffic;
        logic [7:0]  exp_a3 [6];
        logic [15:0] exp_d3 [6];
        logic [7:0]  exp_a4 [4];

        exp_a3 = '{8'h00, 8'h02, 8'h04, 8'h10, 8'h12, 8'h14};
        exp_d3 = '{16'hB2A1, 16'hD4C3, 16'h0201, 16'h2211, 16'h4433, 16'h6655};
        exp_a4 = '{8'hFE, 8'h00, 8'h0E, 8'h10};

        rd_en = 1'b1; rd_lat = 2; wr_lat = 2;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        reset = 1'b1; start = 1'b0;
        origin_addr = '0; stride = '0; rows = '0; cols = '0; mode = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {27'd0, st_read, st_write, busy, done, err}, 32'd0);
        check("rst_addr", {24'd0, base_addr}, 32'd0);
        check("rst_wdata", {16'd0, write_data}, 32'd0);
        check("rst_wcount", {24'd0, word_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single word, byte-swap
        preload(8'h10, 16'h1234);
        b = wr_addr_q.size();
        run_pass(8'h10, 8'h00, 4'd1, 4'd1, 1'b0, 1'b0, wc, e, bd);
        check("t1_nwr", wr_addr_q.size() - b, 32'd1);
        if (wr_addr_q.size() > b) begin
            check("t1_addr", {24'd0, wr_addr_q[b]}, 32'h10);
            check("t1_data", {16'd0, wr_data_q[b]}, 32'h3412);
        end
        check("t1_wcount", {24'd0, wc}, 32'd1);
        check("t1_err", {31'd0, e}, 32'd0);

        // Single word, bit-reverse
        preload(8'h10, 16'h1234);
        run_pass(8'h10, 8'h00, 4'd1, 4'd1, 1'b1, 1'b0, wc, e, bd);
        check("t2_wdata", {16'd0, write_data}, 32'h2C48);
        check("t2_mem", {16'd0, mem[8'h10]}, 32'h2C48);

        // 2x3 region with stride 0x10
        preload(8'h00, 16'hA1B2); preload(8'h02, 16'hC3D4); preload(8'h04, 16'h0102);
        preload(8'h10, 16'h1122); preload(8'h12, 16'h3344); preload(8'h14, 16'h5566);
        b = wr_addr_q.size();
        run_pass(8'h00, 8'h10, 4'd2, 4'd3, 1'b0, 1'b0, wc, e, bd);
        check("t3_nwr", wr_addr_q.size() - b, 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (b + i < wr_addr_q.size()) begin
                check($sformatf("t3_addr%0d", i), {24'd0, wr_addr_q[b+i]}, {24'd0, exp_a3[i]});
                check($sformatf("t3_data%0d", i), {16'd0, wr_data_q[b+i]}, {16'd0, exp_d3[i]});
            end
        end
        check("t3_wcount", {24'd0, wc}, 32'd6);

        // Address wrap, busy held, mid-pass start ignored
        preload(8'hFE, 16'hCAFE); preload(8'h00, 16'hBEEF);
        preload(8'h0E, 16'h1357); preload(8'h10, 16'h2468);
        b = wr_addr_q.size();
        run_pass(8'hFE, 8'h10, 4'd2, 4'd2, 1'b0, 1'b1, wc, e, bd);
        check("t4_nwr", wr_addr_q.size() - b, 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (b + i < wr_addr_q.size())
                check($sformatf("t4_addr%0d", i), {24'd0, wr_addr_q[b+i]}, {24'd0, exp_a4[i]});
        end
        check("t4_data_fe", {16'd0, mem[8'hFE]}, 32'hFECA);
        check("t4_busy_drop", {31'd0, bd}, 32'd0);
        check("t4_wcount", {24'd0, wc}, 32'd4);

        // Zero-size region
        b = wr_addr_q.size();
        rows = 4'd0; cols = 4'd5; origin_addr = 8'h20; start = 1'b1;
        @(negedge clk);
        start = 1'b0; seen = 1'b0; traffic = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (done) seen = 1'b1;
            if (st_read || st_write) traffic = 1'b1;
            @(negedge clk);
        end
        check("t5_done", {31'd0, seen}, 32'd1);
        check("t5_traffic", {31'd0, traffic}, 32'd0);
        check("t5_wcount", {24'd0, word_count}, 32'd0);
        check("t5_nwr", wr_addr_q.size() - b, 32'd0);

        // Stalled read -> timeout
        rd_en = 1'b0;
        origin_addr = 8'h30; stride = 8'h00; rows = 4'd1; cols = 4'd1; mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; cnt = 0;
        while (!done && cnt < 100) begin
            if (st_read) cnt++;
            @(negedge clk);
        end
        check("t6_rd_cycles", cnt, 32'd15);
        check("t6_done", {31'd0, done}, 32'd1);
        check("t6_err", {31'd0, err}, 32'd1);
        check("t6_st_read", {31'd0, st_read}, 32'd0);
        check("t6_wcount", {24'd0, word_count}, 32'd0);
        @(negedge clk);
        rd_en = 1'b1;

        // Working adapter clears err on the next accepted start
        preload(8'h30, 16'h00FF);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t7_err_clr", {31'd0, err}, 32'd0);
        cnt = 0;
        while (!done && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("t7_wdata", {16'd0, write_data}, 32'hFF00);
        @(negedge clk);

        // Reset while waiting for wrt_done
        wr_lat = 6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; cnt = 0;
        while (!st_write && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("t8_st_write_seen", {31'd0, st_write}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t8_rst_ctrl", {27'd0, st_read, st_write, busy, done, err}, 32'd0);
        check("t8_rst_data", {8'd0, base_addr, write_data}, 32'd0);
        check("t8_rst_wcount", {24'd0, word_count}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done || busy) seen = 1'b1;
            @(negedge clk);
        end
        check("t8_no_done", {31'd0, seen}, 32'd0);

        check("handshake", {31'd0, hs_viol}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
